mersenne_sweep_ctrl: RTL and testbench

Upstream sequencer for the Lucas-Lehmer tester. It walks a configured range of exponents and rejects composite exponents with a sequential trial-division prefilter. Prime exponents are launched on the tester through its start/done handshake, with a timeout guard. Every outcome is pushed into a small result FIFO with a valid/ready output toward the host/logging side.

---
 rtl/mersenne_sweep_ctrl_pkg.sv | 57 +++++
 rtl/mersenne_sweep_ctrl_result_fifo.sv | 69 ++++++
 rtl/mersenne_sweep_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mersenne_sweep_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mersenne_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mersenne_pkg
// Description : Shared definitions for the Mersenne exponent sweep controller:
//               FSM state encodings, result source codes, the trial-division
//               divisor table, the result record layout and a constant-divisor
//               divisibility helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mersenne_pkg;

   // Sweep controller states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FILTER = 3'd1;
   localparam state_t ST_LAUNCH = 3'd2;
   localparam state_t ST_WAIT   = 3'd3;
   localparam state_t ST_PUSH   = 3'd4;
   localparam state_t ST_FINISH = 3'd5;

   // Result source codes
   localparam logic [1:0] SRC_LL        = 2'd0;
   localparam logic [1:0] SRC_COMPOSITE = 2'd1;
   localparam logic [1:0] SRC_TIMEOUT   = 2'd2;
   localparam logic [1:0] SRC_DIRECT    = 2'd3;

   // Primes up to sqrt(255); entry 0 is the first divisor tried.
   localparam int NUM_DIVISORS = 6;
   localparam logic [NUM_DIVISORS-1:0][3:0] C_DIVISORS =
      {4'd13, 4'd11, 4'd7, 4'd5, 4'd3, 4'd2};

   // One outcome record (27 bits)
   typedef struct packed {
      logic [7:0]  exponent;
      logic        prime;
      logic [1:0]  src;
      logic [15:0] cycles;
   } result_t;

   localparam int RESULT_W = $bits(result_t);

   // Divisibility by the divisor at table position idx. Each branch is a
   // modulo by a constant, so no general divider is built.
   function automatic logic divides(input logic [7:0] p, input logic [2:0] idx);
      case (idx)
         3'd0:    divides = ((p % 8'd2)  == 8'd0);
         3'd1:    divides = ((p % 8'd3)  == 8'd0);
         3'd2:    divides = ((p % 8'd5)  == 8'd0);
         3'd3:    divides = ((p % 8'd7)  == 8'd0);
         3'd4:    divides = ((p % 8'd11) == 8'd0);
         3'd5:    divides = ((p % 8'd13) == 8'd0);
         default: divides = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mersenne_sweep_ctrl_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mersenne_result_fifo
// Description : Synchronous FIFO for sweep result records. Power-of-two
//               depth, occupancy counter for full/empty, asynchronous
//               active-low reset that clears storage. A push while full is
//               accepted only when a pop happens in the same cycle.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, wr_data  - write request and data
//               pop            - read request (head advance)
//               rd_data        - head entry
//               full, empty    - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module mersenne_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 27
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push_en;
   logic             w_pop_en;

   assign empty     = (r_count == '0);
   assign full      = (r_count == (AW+1)'(DEPTH));
   assign w_pop_en  = pop && !empty;
   assign w_push_en = push && (!full || w_pop_en);
   assign rd_data   = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_en) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_en, w_pop_en})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mersenne_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mersenne_sweep_ctrl
// Description : Walks an exponent range, rejects composite exponents with a
//               one-divisor-per-cycle trial-division prefilter, launches
//               prime exponents on the Lucas-Lehmer tester with a timeout
//               guard, and queues every outcome in a result FIFO.
// Ports       : sweep_start, cfg_first, cfg_last - sweep request and range
//               ll_start, ll_exponent              - tester launch
//               ll_done, ll_is_prime, ll_cycles    - tester completion
//               res_valid/res_ready, res_*         - result stream
//               busy, sweep_done                   - sweep status
// Revision    : 1.0 - initial release
// ============================================================================
module mersenne_sweep_ctrl
   import mersenne_pkg::*;
#(
   parameter int TIMEOUT    = 4096,
   parameter int TIMEOUT_W  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sweep_start,
   input  logic [7:0]  cfg_first,
   input  logic [7:0]  cfg_last,
   output logic        ll_start,
   output logic [7:0]  ll_exponent,
   input  logic        ll_is_prime,
   input  logic        ll_done,
   input  logic [15:0] ll_cycles,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_exponent,
   output logic        res_prime,
   output logic [1:0]  res_src,
   output logic [15:0] res_cycles,
   output logic        busy,
   output logic        sweep_done
);

   state_t               r_state;
   logic [8:0]           r_cur;       // 9 bits so that last = 255 cannot wrap
   logic [7:0]           r_last;
   logic [2:0]           r_div_idx;
   logic [TIMEOUT_W-1:0] r_tmo_cnt;
   result_t              r_rec;
   logic [7:0]           r_ll_exp;
   logic                 r_busy;
   logic                 r_sweep_done;

   logic [7:0]           w_p;
   logic [7:0]           w_div;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_pop;
   logic                 w_push;
   logic [RESULT_W-1:0]  w_fifo_rdata;
   result_t              w_head;

   assign w_p   = r_cur[7:0];
   assign w_div = {4'd0, C_DIVISORS[r_div_idx]};

   // A full FIFO still takes a record when the head is popped this cycle.
   assign w_pop  = !w_fifo_empty && res_ready;
   assign w_push = (r_state == ST_PUSH) && (!w_fifo_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cur        <= '0;
         r_last       <= '0;
         r_div_idx    <= '0;
         r_tmo_cnt    <= '0;
         r_rec        <= '0;
         r_ll_exp     <= '0;
         r_busy       <= 1'b0;
         r_sweep_done <= 1'b0;
      end else begin
         r_sweep_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sweep_start) begin
                  r_cur     <= {1'b0, cfg_first};
                  r_last    <= cfg_last;
                  r_div_idx <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= (cfg_first > cfg_last) ? ST_FINISH : ST_FILTER;
               end
            end

            ST_FILTER: begin
               if (w_p < 8'd2) begin
                  r_rec   <= '{exponent: w_p, prime: 1'b0, src: SRC_COMPOSITE, cycles: 16'd0};
                  r_state <= ST_PUSH;
               end else if (w_p == w_div) begin
                  // p equals a table divisor, so p is prime. Only p = 2
                  // (entry 0) is answered directly; M_2 = 3 is prime.
                  if (r_div_idx == 3'd0) begin
                     r_rec   <= '{exponent: w_p, prime: 1'b1, src: SRC_DIRECT, cycles: 16'd0};
                     r_state <= ST_PUSH;
                  end else begin
                     r_ll_exp <= w_p;
                     r_state  <= ST_LAUNCH;
                  end
               end else if (divides(w_p, r_div_idx)) begin
                  r_rec   <= '{exponent: w_p, prime: 1'b0, src: SRC_COMPOSITE, cycles: 16'd0};
                  r_state <= ST_PUSH;
               end else if (r_div_idx == 3'(NUM_DIVISORS - 1)) begin
                  r_ll_exp <= w_p;
                  r_state  <= ST_LAUNCH;
               end else begin
                  r_div_idx <= r_div_idx + 3'd1;
               end
            end

            ST_LAUNCH: begin
               r_tmo_cnt <= '0;
               r_state   <= ST_WAIT;
            end

            ST_WAIT: begin
               r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
               // Tester completion takes priority over a coincident timeout.
               if (ll_done) begin
                  r_rec   <= '{exponent: r_ll_exp, prime: ll_is_prime, src: SRC_LL, cycles: ll_cycles};
                  r_state <= ST_PUSH;
               end else if (r_tmo_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
                  r_rec   <= '{exponent: r_ll_exp, prime: 1'b0, src: SRC_TIMEOUT, cycles: 16'd0};
                  r_state <= ST_PUSH;
               end
            end

            ST_PUSH: begin
               if (w_push) begin
                  if (r_cur == {1'b0, r_last}) begin
                     r_state <= ST_FINISH;
                  end else begin
                     r_cur     <= r_cur + 9'd1;
                     r_div_idx <= '0;
                     r_state   <= ST_FILTER;
                  end
               end
            end

            ST_FINISH: begin
               r_sweep_done <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   mersenne_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RESULT_W)
   ) u_result_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (w_push),
      .wr_data (r_rec),
      .pop     (w_pop),
      .rd_data (w_fifo_rdata),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty)
   );

   assign w_head       = w_fifo_rdata;
   assign res_valid    = !w_fifo_empty;
   assign res_exponent = w_head.exponent;
   assign res_prime    = w_head.prime;
   assign res_src      = w_head.src;
   assign res_cycles   = w_head.cycles;

   assign ll_start    = (r_state == ST_LAUNCH);
   assign ll_exponent = r_ll_exp;
   assign busy        = r_busy;
   assign sweep_done  = r_sweep_done;

endmodule
`default_nettype wire

// File: tb/tb_mersenne_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mersenne_sweep_ctrl
// Description : Self-checking bench for mersenne_sweep_ctrl. A table of sweeps
//               with expected launch counts and latencies, a behavioural
//               tester, a reference model feeding a record scoreboard, plus
//               hand-written backpressure and mid-sweep reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mersenne_sweep_ctrl;

   localparam int TMO = 64;

   logic        clk;
   logic        rst_n;
   logic        sweep_start;
   logic [7:0]  cfg_first;
   logic [7:0]  cfg_last;
   logic        ll_start;
   logic [7:0]  ll_exponent;
   logic        ll_is_prime;
   logic        ll_done;
   logic [15:0] ll_cycles;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_exponent;
   logic        res_prime;
   logic [1:0]  res_src;
   logic [15:0] res_cycles;
   logic        busy;
   logic        sweep_done;

   mersenne_sweep_ctrl #(
      .TIMEOUT    (TMO),
      .TIMEOUT_W  (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sweep_start  (sweep_start),
      .cfg_first    (cfg_first),
      .cfg_last     (cfg_last),
      .ll_start     (ll_start),
      .ll_exponent  (ll_exponent),
      .ll_is_prime  (ll_is_prime),
      .ll_done      (ll_done),
      .ll_cycles    (ll_cycles),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_exponent (res_exponent),
      .res_prime    (res_prime),
      .res_src      (res_src),
      .res_cycles   (res_cycles),
      .busy         (busy),
      .sweep_done   (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Exponents whose Mersenne number is prime (p <= 255)
   function automatic logic mers(input int p);
      return (p inside {2, 3, 5, 7, 13, 17, 19, 31, 61, 89, 107, 127});
   endfunction

   // Expected record {exponent, prime, src, cycles} for exponent p
   function automatic logic [26:0] exp_rec(input int p, input int delay, input int silent);
      bit pr;
      pr = (p >= 2);
      for (int d = 2; d < p; d++) if (p % d == 0) pr = 1'b0;
      if (!pr)         return {8'(p), 1'b0, 2'd1, 16'd0};
      if (p == 2)      return {8'(p), 1'b1, 2'd3, 16'd0};
      if (p == silent) return {8'(p), 1'b0, 2'd2, 16'd0};
      return {8'(p), mers(p), 2'd0, 16'(delay)};
   endfunction

   // Scoreboard and observation state
   logic [26:0] exp_q[$];
   int  n_launch   = 0;
   int  launch_cyc = -1;
   int  rise_cyc   = -1;
   logic prev_valid = 1'b0;
   int  cur_delay  = 5;
   int  cur_silent = 255;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ll_start) begin
            n_launch++;
            if (launch_cyc < 0) launch_cyc = cyc;
         end
         if (res_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0)
               chk("unexpected_record_count", 64'(exp_q.size() + 1), 64'd0);
            else
               chk("record", {res_exponent, res_prime, res_src, res_cycles}, exp_q.pop_front());
         end
      end
      prev_valid = res_valid;
   end

   // Behavioural Lucas-Lehmer tester: answers cur_delay cycles after the
   // launch cycle unless the exponent is the silent one.
   initial begin : tester
      logic [7:0] e;
      ll_done     = 1'b0;
      ll_is_prime = 1'b0;
      ll_cycles   = 16'hDEAD;
      forever begin
         @(negedge clk);
         if (ll_start && rst_n) begin
            e = ll_exponent;
            if (int'(e) != cur_silent) begin
               repeat (cur_delay) @(posedge clk);
               #1;
               chk("ll_exponent_hold", 64'(ll_exponent), 64'(e));
               ll_done     = 1'b1;
               ll_is_prime = mers(int'(e));
               ll_cycles   = 16'(cur_delay);
               @(posedge clk);
               #1;
               ll_done     = 1'b0;
               ll_is_prime = 1'b0;
               ll_cycles   = 16'hDEAD;
            end
         end
      end
   end

   task automatic start_sweep(input int first, input int last, input int delay, input int silent);
      cur_delay  = delay;
      cur_silent = silent;
      n_launch   = 0;
      launch_cyc = -1;
      rise_cyc   = -1;
      for (int p = first; p <= last; p++) exp_q.push_back(exp_rec(p, delay, silent));
      @(posedge clk);
      #1;
      sweep_start = 1'b1;
      cfg_first   = 8'(first);
      cfg_last    = 8'(last);
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic finish_sweep(input int exp_l, input int exp_lat, input int done_lat);
      int lat;
      int k;
      lat = 1;
      while (!sweep_done && lat < 4000) begin
         @(negedge clk);
         lat++;
      end
      chk("sweep_done_seen", 64'(sweep_done), 64'd1);
      chk("busy_low_at_done", 64'(busy), 64'd0);
      if (done_lat > 0) chk("sweep_done_latency", 64'(lat), 64'(done_lat));
      @(negedge clk);
      chk("sweep_done_one_cycle", 64'(sweep_done), 64'd0);
      k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      chk("fifo_empty_after", 64'(res_valid), 64'd0);
      chk("launch_count", 64'(n_launch), 64'(exp_l));
      if (exp_lat > 0) chk("launch_to_valid", 64'(rise_cyc - launch_cyc), 64'(exp_lat));
   endtask

   typedef struct {
      int first;
      int last;
      int delay;
      int silent;
      int exp_launch;
      int exp_lat;    // ll_start cycle to res_valid rise, 0 = not checked
      int done_lat;   // sweep_start cycle to sweep_done, 0 = not checked
   } vec_t;

   vec_t tbl[8];

   initial begin : main
      int k;
      int l1;
      // done at launch+40, one PUSH cycle, then visible: 42
      tbl[0] = '{13,  13,  40, 255, 1, 42, 0};
      tbl[1] = '{10,  13,   9, 255, 2,  0, 0};
      tbl[2] = '{0,    3,   5, 255, 1,  0, 0};
      // timeout decision on the 64th cycle after launch, then PUSH, then visible
      tbl[3] = '{23,  23,  10,  23, 1, 66, 0};
      // done coincides with timeout: done wins
      tbl[4] = '{17,  17,  64, 255, 1, 66, 0};
      tbl[5] = '{20,   5,   5, 255, 0,  0, 2};
      tbl[6] = '{100, 130,  3, 255, 6,  0, 0};
      tbl[7] = '{250, 255,  3, 255, 1,  0, 0};

      rst_n       = 1'b0;
      sweep_start = 1'b0;
      cfg_first   = 8'd0;
      cfg_last    = 8'd0;
      res_ready   = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {ll_start, ll_exponent, res_valid, res_exponent, res_prime, res_src, res_cycles, busy, sweep_done},
          64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         start_sweep(tbl[i].first, tbl[i].last, tbl[i].delay, tbl[i].silent);
         finish_sweep(tbl[i].exp_launch, tbl[i].exp_lat, tbl[i].done_lat);
      end

      // Backpressure: four records fill the FIFO, the fifth stalls in PUSH.
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      start_sweep(2, 31, 4, 255);
      repeat (400) @(negedge clk);
      chk("stall_launches", 64'(n_launch), 64'd2);
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_head", {res_valid, res_exponent}, {1'b1, 8'd2});
      l1 = n_launch;
      repeat (50) @(negedge clk);
      chk("stall_no_new_launch", 64'(n_launch), 64'(l1));
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      finish_sweep(10, 0, 0);

      // Reset while waiting on the tester, then a clean sweep.
      start_sweep(23, 23, 10, 23);
      k = 0;
      while (n_launch == 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("mid_reset_launch_seen", 64'(n_launch), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_reset_outputs",
          {ll_start, ll_exponent, res_valid, res_exponent, res_prime, res_src, res_cycles, busy, sweep_done},
          64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_sweep(7, 7, 6, 255);
      finish_sweep(1, 8, 0);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
